// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state type, opcode constants and width defaults for the ALU arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int OP_W_DEF = 4;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_MOV = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_B = 4'hC;
  localparam logic [3:0] OP_BR = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] OP_IDLE = 4'hF;
endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant scanning upward from the last winner
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);
  logic [IW-1:0] last, j;
  logic found;
  // First requesting index found after last, wrapping around
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(last) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = j;
      end
    end
  end
  // Pointer tracks the last winner; reset value puts requester 0 first in line
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= IW'(NUM_REQ - 1);
    else if (advance) last <= grant_idx;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among requesters, one issue cycle per op; ALU_ARB_LOCK_EN adds flag-private locking
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W = OP_W_DEF,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         alu_in1,
  output logic [DATA_W-1:0]         alu_in2,
  output logic [OP_W-1:0]           alu_opcode,
  input  logic [DATA_W-1:0]         alu_out,
  output logic                      busy
`ifdef ALU_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic                      locked
`endif
);
  state_t state, state_nx;
  logic [NUM_REQ-1:0] arb_req, grant;
  logic [IW-1:0] grant_idx, owner;
  logic [OP_W-1:0] sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic accept;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk(clk),
    .rst(rst),
    .req(arb_req),
    .advance(accept),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  assign req_ready = state == IDLE ? grant : '0;
  assign accept = |req_ready;
  assign busy = state != IDLE;
  assign sel_op = OP_W'(req_op >> (OP_W * int'(grant_idx)));
  assign sel_a = DATA_W'(req_a >> (DATA_W * int'(grant_idx)));
  assign sel_b = DATA_W'(req_b >> (DATA_W * int'(grant_idx)));
`ifdef ALU_ARB_LOCK_EN
  logic [IW-1:0] lock_idx;
  assign arb_req = locked ? req_valid & (NUM_REQ'(1) << lock_idx) : req_valid;
  // Lock follows the req_lock bit of each accepted request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      locked <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      locked <= req_lock[grant_idx];
      lock_idx <= grant_idx;
    end
`else
  assign arb_req = req_valid;
`endif
  // Next state: accept -> single issue cycle -> hold response until taken
  always_comb
    state_nx = state == IDLE ? (accept ? ISSUE : IDLE) : state == ISSUE ? RESP : (rsp_ready[owner] ? IDLE : RESP);
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // ALU drive registers and response capture; opcode is idle outside the issue cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_opcode <= OP_W'(OP_IDLE);
      rsp_valid <= '0;
      rsp_data <= '0;
      owner <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= sel_op;
        alu_in1 <= sel_a;
        alu_in2 <= sel_b;
        owner <= grant_idx;
      end
      if (state == ISSUE) begin
        alu_opcode <= OP_W'(OP_IDLE);
        rsp_data <= alu_out;
        rsp_valid <= NUM_REQ'(1) << owner;
      end
      if (state == RESP && rsp_ready[owner]) rsp_valid <= '0;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and scoreboarded bench for alu_arbiter with a small ALU stand-in
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  localparam int N = 3;
  localparam int DW = 16;
  localparam int OW = 4;
  typedef struct {
    int idx;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    bit care;
    logic [2:0] nzv;
  } vec_t;
  typedef struct {
    int idx;
    logic [15:0] data;
    bit care;
  } sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*OW-1:0] req_op = '0;
  logic [N*DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] rsp_data, alu_in1, alu_in2, alu_out;
  logic [OW-1:0] alu_opcode;
  logic busy;
  logic fn, fz, fv;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0] req_lock = '0;
  logic locked;
`endif
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_res [N];
  bit exp_care [N];
  sb_t sb [$];
  bit prev_acc;
  int got [8];
  int gcnt;
  vec_t tbl [10];

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .alu_in1(alu_in1),
    .alu_in2(alu_in2),
    .alu_opcode(alu_opcode),
    .alu_out(alu_out),
    .busy(busy)
`ifdef ALU_ARB_LOCK_EN
    ,
    .req_lock(req_lock),
    .locked(locked)
`endif
  );

  always #5 clk = ~clk;

  always_comb
    case (alu_opcode)
      OP_ADD: alu_out = alu_in1 + alu_in2;
      OP_SUB: alu_out = alu_in1 - alu_in2;
      OP_XOR: alu_out = alu_in1 ^ alu_in2;
      OP_AND: alu_out = alu_in1 & alu_in2;
      OP_OR: alu_out = alu_in1 | alu_in2;
      default: alu_out = alu_in1;
    endcase

  always @(posedge clk or posedge rst)
    if (rst) begin
      fn <= 1'b0;
      fz <= 1'b0;
      fv <= 1'b0;
    end else if (alu_opcode < 4'hC) begin
      fn <= alu_out[15];
      fz <= alu_out == 16'h0;
      fv <= alu_opcode == OP_ADD ? (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15])
          : alu_opcode == OP_SUB ? (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]) : 1'b0;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    idx_of = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) idx_of = i;
  endfunction

  task automatic drive(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e, input bit care);
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    exp_res[i] = e;
    exp_care[i] = care;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    int n = 0;
    #1;
    while (!req_ready[i] && n < 40) begin
      @(posedge clk); #3;
      n++;
    end
    chk("accept", req_ready[i], 1);
    @(posedge clk); #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (busy && n < 40) begin
      @(posedge clk); #3;
      n++;
    end
    chk("idle_timeout", busy, 0);
    @(posedge clk); #2;
  endtask

  task automatic send(input vec_t v);
    drive(v.idx, v.op, v.a, v.b, v.exp, v.care);
    wait_acc(v.idx);
    #1;
    chk("issue_op", alu_opcode, v.op);
    chk("issue_a", alu_in1, v.a);
    chk("issue_b", alu_in2, v.b);
    @(posedge clk); #3;
    chk("rsp_valid", rsp_valid, 1 << v.idx);
    if (v.care) begin
      chk("rsp_data", rsp_data, v.exp);
      chk("flags_nzv", {fn, fz, fv}, v.nzv);
    end
    wait_idle();
  endtask

  task automatic collect(input int cnt);
    int n = 0;
    gcnt = 0;
    foreach (got[k]) got[k] = -1;
    #1;
    while (gcnt < cnt && n < 60) begin
      if (|req_ready) begin
        got[gcnt] = idx_of(req_ready);
        gcnt++;
      end
      if (gcnt < cnt) begin
        @(posedge clk); #3;
      end
      n++;
    end
    chk("grant_count", gcnt, cnt);
    @(posedge clk); #2;
  endtask

  initial begin
    tbl[0] = '{0, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 3'b101};
    tbl[1] = '{1, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 3'b010};
    tbl[2] = '{2, OP_XOR, 16'h00F0, 16'h000F, 16'h00FF, 1'b1, 3'b000};
    tbl[3] = '{0, OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1, 3'b000};
    tbl[4] = '{1, OP_OR, 16'h1200, 16'h0034, 16'h1234, 1'b1, 3'b000};
    tbl[5] = '{0, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3'b010};
    tbl[6] = '{1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3'b100};
    tbl[7] = '{0, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 3'b001};
    tbl[8] = '{0, OP_B, 16'h1234, 16'h0000, 16'h0000, 1'b0, 3'b000};
    tbl[9] = '{2, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b1, 3'b000};
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          sb.delete();
          prev_acc = 1'b0;
        end else begin
          chk("issue_window", alu_opcode != OP_IDLE, prev_acc);
          chk("ready_onehot", $countones(req_ready) <= 1, 1);
          chk("rspv_onehot", $countones(rsp_valid) <= 1, 1);
          prev_acc = |(req_valid & req_ready);
          if (prev_acc) begin
            int w;
            w = idx_of(req_ready);
            sb.push_back('{w, exp_res[w], exp_care[w]});
          end
          if (|(rsp_valid & rsp_ready)) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL rsp_unexpected actual=%0h expected=none", rsp_valid);
            end else begin
              sb_t e;
              e = sb.pop_front();
              chk("rsp_idx", idx_of(rsp_valid), e.idx);
              if (e.care) chk("sb_data", rsp_data, e.data);
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_opcode", alu_opcode, OP_IDLE);
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    rsp_ready = '1;
    repeat (10) begin
      @(posedge clk); #3;
      chk("idle_opcode", alu_opcode, OP_IDLE);
      chk("idle_ready", req_ready, 0);
      chk("idle_flags", {fn, fz, fv}, 0);
      chk("idle_busy", busy, 0);
    end
    @(posedge clk); #2;
    for (int k = 0; k < 10; k++) send(tbl[k]);
    drive(0, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    drive(1, OP_XOR, 16'h00FF, 16'h00FF, 16'h0000, 1'b1);
    collect(4);
    req_valid = '0;
    for (int k = 0; k < 4; k++) chk("alt_grant", got[k], k % 2);
    wait_idle();
    drive(0, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    drive(1, OP_XOR, 16'h00FF, 16'h00FF, 16'h0000, 1'b1);
    drive(2, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b1);
    collect(6);
    req_valid = '0;
    for (int k = 0; k < 6; k++) chk("rot_grant", got[k], (k + 2) % 3);
    wait_idle();
    rsp_ready = 3'b101;
    drive(1, OP_XOR, 16'h00F0, 16'h000F, 16'h00FF, 1'b1);
    wait_acc(1);
    drive(0, OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b1);
    @(posedge clk); #3;
    repeat (5) begin
      chk("hold_rspv", rsp_valid, 3'b010);
      chk("hold_data", rsp_data, 16'h00FF);
      chk("hold_ready", req_ready, 0);
      @(posedge clk); #3;
    end
    rsp_ready = '1;
    @(posedge clk); #3;
    chk("after_hold_ready", req_ready, 3'b001);
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
    drive(2, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b1);
    wait_acc(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_opcode", alu_opcode, OP_IDLE);
    chk("mid_rst_in1", alu_in1, 0);
    chk("mid_rst_in2", alu_in2, 0);
    chk("mid_rst_rspv", rsp_valid, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    drive(0, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    drive(1, OP_XOR, 16'h00FF, 16'h00FF, 16'h0000, 1'b1);
    drive(2, OP_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b1);
    #1;
    chk("post_rst_grant", req_ready, 3'b001);
    @(posedge clk); #2;
    req_valid = '0;
    wait_idle();
`ifdef ALU_ARB_LOCK_EN
    drive(0, OP_SUB, 16'h0009, 16'h0009, 16'h0000, 1'b1);
    req_lock = 3'b001;
    wait_acc(0);
    req_lock = '0;
    #1;
    chk("lock_set", locked, 1);
    drive(1, OP_XOR, 16'h00F0, 16'h000F, 16'h00FF, 1'b1);
    wait_idle();
    repeat (4) begin
      #1;
      chk("lock_block", req_ready, 0);
      chk("lock_held", locked, 1);
      @(posedge clk); #2;
    end
    drive(0, OP_ADD, 16'h0002, 16'h0002, 16'h0004, 1'b1);
    #1;
    chk("lock_owner_grant", req_ready, 3'b001);
    @(posedge clk); #2;
    req_valid[0] = 1'b0;
    #1;
    chk("lock_clear", locked, 0);
    wait_acc(1);
    wait_idle();
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU datapath (16-bit operands, 4-bit opcode, registered N/Z/V flags inside the ALU) between requesters, e.g. the main decode stage and the address-generation/debug unit.
- Round-robin arbitration, valid/ready on both request and response sides.
- Drives the ALU for exactly one cycle per accepted operation, so the ALU flag registers are written once per operation and never while idle.
- Sits between the requesters and the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 16, operand/result width; must match the ALU.
- OP_W, 4, opcode width; must match the ALU.

Ports:
- clk  in  1  system clock; the same clock drives the ALU flag registers.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  NUM_REQ*OP_W  packed opcodes; requester i uses bits [i*OP_W +: OP_W].
- req_a  in  NUM_REQ*DATA_W  packed operand 1.
- req_b  in  NUM_REQ*DATA_W  packed operand 2.
- rsp_valid  out  NUM_REQ  result valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  DATA_W  result, shared by all requesters.
- alu_in1  out  DATA_W  to ALU operand 1.
- alu_in2  out  DATA_W  to ALU operand 2.
- alu_opcode  out  OP_W  to ALU opcode.
- alu_out  in  DATA_W  from ALU result (combinational).
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0.
  - alu_in1=alu_in2=0, alu_opcode=OP_IDLE (4'hF), busy=0.
  - Round-robin pointer set so requester 0 has highest priority.
- OP_IDLE is 4'hF, which writes no ALU flags. alu_opcode equals OP_IDLE in every cycle except ISSUE.
- IDLE:
  - Winner = first requester with req_valid=1, scanning upward from (last_grant+1) mod NUM_REQ.
  - req_ready[winner]=1, combinational from req_valid and pointer. No other ready bit is set.
  - On req_valid&req_ready: register op/a/b into the ALU output registers, store the grant index, update the pointer to the winner, go to ISSUE.
  - With no valid request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - alu_opcode/in1/in2 carry the captured operation.
  - The ALU flags update at the closing edge.
  - At that edge, rsp_data<=alu_out, rsp_valid[grant]<=1, alu_opcode<=OP_IDLE; go to RESP.
- RESP:
  - rsp_valid[grant] and rsp_data are held stable until rsp_ready[grant]=1.
  - On that edge: rsp_valid<=0, go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
  - No new request is accepted in RESP.
- Latency:
  - Accept edge at cycle 0, ISSUE in cycle 1, rsp_valid high from cycle 2.
  - With rsp_ready held high, throughput is 1 op per 3 cycles.
- Opcodes 4'hC..4'hF (B/BR/PCS/HLT) are passed through unchanged. rsp_data then reflects whatever alu_out drives, and the requester ignores it.
- Requests that are not granted are held by the requester. The arbiter never drops a request it has not accepted.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,...,NUM_REQ-1,0.
  - A lone requester is granted repeatedly.
- Reset mid-ISSUE or mid-RESP: the operation is abandoned and no response is given. The ALU flags may already hold that op's update; the ALU's own rst clears them.
- The ALU flags belong to the last issued op only. A requester relying on flags must consume them before another requester's op is issued (see the lock feature below).

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- With the macro defined:
  - Extra input port req_lock, NUM_REQ bits.
  - If the accepted request has req_lock[i]=1, the next IDLE arbitration grants only requester i. Others get no ready, even if requester i is not valid. This keeps the flags private across dependent ops (e.g. SUB followed by a branch-condition read).
  - The lock clears when requester i's accepted request has req_lock=0, or on reset.
  - Output locked (1 bit) is high while the lock is held.
- Without the macro: req_lock and locked are absent, and arbitration is pure round-robin.

Decomposition:
- Package alu_arb_pkg contains:
  - state enum {IDLE, ISSUE, RESP}.
  - OP_IDLE=4'hF, DATA_W/OP_W defaults.
  - Opcode localparams ADD=0, SUB=1, XOR=2, ... HLT=F, for bench use.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant.
  - Inputs: req vector, pointer.
  - Output: one-hot grant.
  - Pointer update on an advance strobe.

Test Plan:
- Reset, then idle for 10 cycles -> alu_opcode=4'hF throughout, req_ready=0 with no valid, ALU N/Z/V stay 0.
- Req0 ADD a=16'h7FFF b=16'h0001, rsp_ready=1:
  - Accept at cycle 0; alu_opcode=0 in cycle 1 only.
  - rsp_valid[0]=1 with rsp_data=16'h8000 in cycle 2.
  - ALU V=1, N=1.
- Req0 and req1 both valid continuously (SUB 5-5, XOR FF^FF):
  - Grants alternate 0,1,0,1.
  - Each rsp_data=0; alu_opcode is non-F for exactly one cycle per op.
- Req1 XOR 16'h00F0^16'h000F with rsp_ready[1]=0 for 5 cycles:
  - rsp_valid[1] and rsp_data=16'h00FF held stable.
  - req0 stays unaccepted until rsp_ready[1]=1.
- Assert rst during ISSUE -> outputs return to reset values immediately; no rsp_valid; next grant goes to requester 0.
- ALU_ARB_LOCK_EN: req0 SUB with lock=1, req1 valid throughout:
  - Req1 is not granted until req0 issues a request with lock=0.
  - locked is high for that interval.
